// File: rtl/uart_link_ctrl.sv
// UART link controller: handshake/echo-guarded fetch (host -> write FIFO) and readback (read FIFO -> host).
// Define UART_PARITY_EN to add an even-parity bit to every TX and RX frame.
module uart_link_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 7_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter logic [7:0]  FH_SHAKE    = 8'hDD,
  parameter logic [7:0]  RB_SHAKE    = 8'hAA,
  parameter int unsigned LEN_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_fh,
  input  logic                 start_rb,
  input  logic [LEN_W-1:0]     xfer_len,
  input  logic                 txd_in,
  output logic                 rxd_out,
  output logic [DATA_BITS-1:0] dout,
  output logic                 wr_en,
  input  logic                 full,
  input  logic [DATA_BITS-1:0] din,
  output logic                 rd_en,
  input  logic                 empty,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD_RATE - 1) / BAUD_RATE;
`ifdef UART_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NB = 1 + DATA_BITS + PAR + STOP_BITS;
  localparam int unsigned CW = $clog2(DIV + 1);
  localparam int unsigned PW = $clog2(NB + 1);
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(NB - 1);
  localparam logic [PW-1:0] POS_DLAST = PW'(DATA_BITS);
  localparam logic [PW-1:0] POS_PAR   = PW'(DATA_BITS + 1);
  localparam logic [DATA_BITS-1:0] FH_B = FH_SHAKE[DATA_BITS-1:0];
  localparam logic [DATA_BITS-1:0] RB_B = RB_SHAKE[DATA_BITS-1:0];

  typedef enum logic [3:0] {
    IDLE, FH_TX, FH_ECHO, FH_DATA, RB_TX, RB_ECHO, RB_FETCH, RB_SEND, FIN
  } state_t;

  state_t state, state_nx;

  logic                 rx_s1, rx_s2, rx_s3, rx_act, rx_bad, rx_valid, rx_ferr;
  logic [CW-1:0]        rx_cnt;
  logic [PW-1:0]        rx_pos;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick, rx_end, rx_ok, wr_ok;

  logic                 tx_busy, tx_load;
  logic [DATA_BITS-1:0] tx_data;
  logic [NB-2:0]        tx_shift, tx_frame;
  logic [CW-1:0]        tx_cnt;
  logic [PW-1:0]        tx_pos;

  logic [LEN_W-1:0]     cnt;
  logic                 cnt_dec, err_set, accept, rb_first;
  logic [DATA_BITS-1:0] echo_b;

  assign rx_tick = rx_act && (rx_cnt == '0);
  assign rx_end  = rx_tick && (rx_pos == POS_LAST);
  // Last sample is always a stop bit, so the live line value completes the check.
  assign rx_ok   = rx_end && !rx_bad && rx_s2;
  assign wr_ok   = rx_ok && (state == FH_DATA) && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_act   <= 1'b0;
      rx_bad   <= 1'b0;
      rx_cnt   <= '0;
      rx_pos   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      dout     <= '0;
      wr_en    <= 1'b0;
    end else begin
      rx_s1    <= txd_in;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= rx_ok;
      rx_ferr  <= rx_end && !rx_ok;
      wr_en    <= wr_ok;
      if (wr_ok) dout <= rx_shift;
      if (!rx_act) begin
        if (rx_s3 && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF_M1;
          rx_pos <= '0;
          rx_bad <= 1'b0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= DIV_M1;
        rx_pos <= rx_pos + PW'(1);
        if (rx_pos == '0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_pos <= POS_DLAST) begin
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
        end else if ((PAR != 0) && (rx_pos == POS_PAR)) begin
          if (rx_s2 != ^rx_shift) rx_bad <= 1'b1;
        end else if (!rx_s2) begin
          rx_bad <= 1'b1;
        end
        if (rx_pos == POS_LAST) rx_act <= 1'b0;
      end
    end
  end

  always_comb begin
    tx_frame = '1;
    tx_frame[DATA_BITS-1:0] = tx_data;
    if (PAR != 0) tx_frame[DATA_BITS] = ^tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_out  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_pos   <= '0;
    end else if (tx_load) begin
      rxd_out  <= 1'b0;
      tx_shift <= tx_frame;
      tx_busy  <= 1'b1;
      tx_cnt   <= DIV_M1;
      tx_pos   <= '0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CW'(1);
      end else if (tx_pos == POS_LAST) begin
        tx_busy <= 1'b0;
      end else begin
        rxd_out  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[NB-2:1]};
        tx_cnt   <= DIV_M1;
        tx_pos   <= tx_pos + PW'(1);
      end
    end
  end

  assign accept = (state == IDLE) && (start_fh || start_rb);
  assign echo_b = (state == FH_ECHO) ? FH_B : RB_B;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      rb_first <= 1'b0;
    end else begin
      state    <= state_nx;
      rb_first <= (state == RB_FETCH) && !empty;
      if (accept)       cnt <= xfer_len;
      else if (cnt_dec) cnt <= cnt - LEN_W'(1);
      if (accept)       err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start_rb) state_nx = RB_TX;
                else if (start_fh) state_nx = FH_TX;
      FH_TX:    if (!tx_busy) state_nx = FH_ECHO;
      RB_TX:    if (!tx_busy) state_nx = RB_ECHO;
      FH_ECHO, RB_ECHO: begin
        if (rx_ferr || (rx_valid && (rx_shift != echo_b))) state_nx = FIN;
        else if (rx_valid) begin
          if (cnt == '0)             state_nx = FIN;
          else if (state == FH_ECHO) state_nx = FH_DATA;
          else                       state_nx = RB_FETCH;
        end
      end
      FH_DATA:  if (rx_valid && (cnt == LEN_W'(1))) state_nx = FIN;
      RB_FETCH: if (!empty) state_nx = RB_SEND;
      RB_SEND:  if (!rb_first && !tx_busy)
                  state_nx = (cnt == LEN_W'(1)) ? FIN : RB_FETCH;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // rb_first marks the cycle where din (requested by last cycle's rd_en) is valid.
  always_comb begin
    tx_load = 1'b0;
    tx_data = FH_B;
    rd_en   = 1'b0;
    cnt_dec = 1'b0;
    err_set = 1'b0;
    busy    = (state != IDLE) && (state != FIN);
    done    = (state == FIN);
    case (state)
      IDLE: begin
        if (start_rb) begin
          tx_load = 1'b1;
          tx_data = RB_B;
        end else if (start_fh) begin
          tx_load = 1'b1;
        end
      end
      FH_ECHO, RB_ECHO: err_set = rx_ferr || (rx_valid && (rx_shift != echo_b));
      FH_DATA: begin
        cnt_dec = rx_valid;
        err_set = rx_ferr || (rx_valid && !wr_en);
      end
      RB_FETCH: rd_en = !empty;
      RB_SEND: begin
        if (rb_first) begin
          tx_load = 1'b1;
          tx_data = din;
        end else begin
          cnt_dec = !tx_busy;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: acts as the serial host and as both FIFOs.
module tb_uart_link_ctrl;
  localparam int DIV = 61;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR    = (10 + PB) * DIV;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0, rst = 1'b0, start_fh = 1'b0, start_rb = 1'b0;
  logic        txd_in = 1'b1, full = 1'b0;
  logic [15:0] xfer_len = '0;
  logic [7:0]  din = '0;
  logic        rxd_out, wr_en, rd_en, empty, busy, done, err;
  logic [7:0]  dout;

  int total = 0, bad = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, db_cnt = 0;
  logic [7:0] wr_log [0:63];
  logic [7:0] fifo_mem [0:7];
  int wp = 0, rp = 0;
  logic hold_empty = 1'b0;

  always #5 clk = ~clk;

  uart_link_ctrl #(
    .CLK_FREQ_HZ(7_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1),
    .FH_SHAKE(8'hDD), .RB_SHAKE(8'hAA), .LEN_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start_fh(start_fh), .start_rb(start_rb),
    .xfer_len(xfer_len), .txd_in(txd_in), .rxd_out(rxd_out), .dout(dout),
    .wr_en(wr_en), .full(full), .din(din), .rd_en(rd_en), .empty(empty),
    .busy(busy), .done(done), .err(err)
  );

  assign empty = (rp == wp) || hold_empty;

  always @(posedge clk) begin
    if (rd_en) begin
      din <= fifo_mem[rp % 8];
      rp  <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wr_log[wr_cnt % 64] = dout;
      wr_cnt++;
    end
    if (rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (done && busy) db_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_mem[wp % 8] = v;
    wp++;
  endtask

  task automatic start(input logic fh, input logic rb, input logic [15:0] len);
    xfer_len = len; start_fh = fh; start_rb = rb;
    @(negedge clk);
    start_fh = 1'b0; start_rb = 1'b0;
  endtask

  // fault: 0 clean frame, 1 stop bit low, 2 wrong parity bit
  task automatic send(input logic [7:0] v, input int fault);
    txd_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      txd_in = v[k];
      repeat (DIV) @(negedge clk);
    end
    if (PB != 0) begin
      txd_in = (^v) ^ (fault == 2);
      repeat (DIV) @(negedge clk);
    end
    txd_in = (fault == 1) ? 1'b0 : 1'b1;
    repeat (DIV) @(negedge clk);
    txd_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic recv(input string tag, output logic [7:0] v, output int low_len);
    int g = 0;
    int k;
    logic ok = 1'b1;
    logic seen_hi = 1'b0;
    while (rxd_out === 1'b1 && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_wait"}, (g < LIMIT), 1);
    v = '0;
    low_len = 0;
    for (int i = 0; i < FR; i++) begin
      if (i != 0) @(negedge clk);
      if (!seen_hi && rxd_out === 1'b0) low_len++;
      else seen_hi = 1'b1;
      if (i % DIV == DIV / 2) begin
        k = i / DIV;
        if (k == 0)                 ok = ok & (rxd_out === 1'b0);
        else if (k <= 8)            v[k-1] = rxd_out;
        else if (PB != 0 && k == 9) ok = ok & (rxd_out === ^v);
        else                        ok = ok & (rxd_out === 1'b1);
      end
    end
    chk({tag, "_frame"}, ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy !== 1'b0 && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    chk(tag, (g < LIMIT), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int lo, w0, r0, d0, g;

    repeat (3) @(negedge clk);
    chk("rst_rxd", rxd_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // fetch of three bytes
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'd3);
    chk("fh_busy_rise", busy, 1);
    chk("fh_start_bit", rxd_out, 0);
    recv("fh_hs", b, lo);
    chk("fh_hs_byte", b, 8'hDD);
    chk("fh_bit_period", lo, 61);
    send(8'hDD, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    wait_idle("fh_idle");
    chk("fh_wr_count", wr_cnt - w0, 3);
    chk("fh_byte0", wr_log[w0], 8'h01);
    chk("fh_byte1", wr_log[w0+1], 8'h02);
    chk("fh_byte2", wr_log[w0+2], 8'h03);
    chk("fh_dout_hold", dout, 8'h03);
    chk("fh_done_count", done_cnt - d0, 1);
    chk("fh_no_rd", rd_cnt - r0, 0);
    chk("fh_err", err, 0);

    // readback of two bytes
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start(1'b0, 1'b1, 16'd2);
    recv("rb_hs", b, lo);
    chk("rb_hs_byte", b, 8'hAA);
    chk("rb_hs_low", lo, 122);
    send(8'hAA, 0);
    push(8'h5A);
    push(8'hC3);
    recv("rb_d0", b, lo);
    chk("rb_byte0", b, 8'h5A);
    recv("rb_d1", b, lo);
    chk("rb_byte1", b, 8'hC3);
    chk("rb_bit_period", lo, 61);
    wait_idle("rb_idle");
    chk("rb_rd_count", rd_cnt - r0, 2);
    chk("rb_done_count", done_cnt - d0, 1);
    chk("rb_no_wr", wr_cnt - w0, 0);
    chk("rb_err", err, 0);

    // simultaneous starts pick readback; starts while busy are ignored
    r0 = rd_cnt; d0 = done_cnt;
    start(1'b1, 1'b1, 16'd1);
    recv("both_hs", b, lo);
    chk("both_hs_byte", b, 8'hAA);
    start(1'b1, 1'b1, 16'd5);
    chk("busy_start_no_tx", rxd_out, 1);
    chk("busy_start_busy", busy, 1);
    send(8'hAA, 0);
    push(8'h3C);
    recv("both_d0", b, lo);
    chk("both_byte0", b, 8'h3C);
    wait_idle("both_idle");
    chk("both_rd_count", rd_cnt - r0, 1);
    chk("both_done_count", done_cnt - d0, 1);

    // wrong echo aborts readback even with data waiting
    r0 = rd_cnt; d0 = done_cnt;
    push(8'h5F);
    start(1'b0, 1'b1, 16'd1);
    recv("we_hs", b, lo);
    send(8'h55, 0);
    wait_idle("we_idle");
    chk("we_err", err, 1);
    chk("we_done_count", done_cnt - d0, 1);
    chk("we_no_rd", rd_cnt - r0, 0);

    // write FIFO full on the second of three bytes
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'd3);
    chk("full_err_cleared", err, 0);
    recv("full_hs", b, lo);
    send(8'hDD, 0);
    send(8'h11, 0);
    full = 1'b1;
    send(8'h22, 0);
    full = 1'b0;
    chk("full_still_busy", busy, 1);
    send(8'h33, 0);
    wait_idle("full_idle");
    chk("full_wr_count", wr_cnt - w0, 2);
    chk("full_byte0", wr_log[w0], 8'h11);
    chk("full_byte1", wr_log[w0+1], 8'h33);
    chk("full_err", err, 1);
    chk("full_done_count", done_cnt - d0, 1);

    // framing error drops the byte without consuming the count
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'd1);
    recv("fe_hs", b, lo);
    send(8'hDD, 0);
    send(8'h44, 1);
    chk("fe_no_wr", wr_cnt - w0, 0);
    chk("fe_err", err, 1);
    chk("fe_still_busy", busy, 1);
    send(8'h45, 0);
    wait_idle("fe_idle");
    chk("fe_wr_count", wr_cnt - w0, 1);
    chk("fe_byte", wr_log[w0], 8'h45);
    chk("fe_done_count", done_cnt - d0, 1);

    // reset in the middle of a readback data frame (5F left in the FIFO)
    hold_empty = 1'b1;
    start(1'b0, 1'b1, 16'd1);
    recv("mr_hs", b, lo);
    send(8'hAA, 0);
    hold_empty = 1'b0;
    g = 0;
    while (rxd_out === 1'b1 && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    chk("mr_frame_wait", (g < LIMIT), 1);
    repeat (390) @(negedge clk);
    chk("mr_pre_low", rxd_out, 0);
    rst = 1'b0;
    #1;
    chk("mr_rxd", rxd_out, 1);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rd", rd_en, 0);
    chk("mr_wr", wr_en, 0);
    chk("mr_err", err, 0);
    chk("mr_dout", dout, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'd1);
    chk("ar_start_bit", rxd_out, 0);
    recv("ar_hs", b, lo);
    chk("ar_hs_byte", b, 8'hDD);
    send(8'hDD, 0);
    send(8'h9C, 0);
    wait_idle("ar_idle");
    chk("ar_wr_count", wr_cnt - w0, 1);
    chk("ar_byte", wr_log[w0], 8'h9C);
    chk("ar_done_count", done_cnt - d0, 1);
    chk("ar_err", err, 0);

`ifdef UART_PARITY_EN
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'd1);
    recv("pe_hs", b, lo);
    send(8'hDD, 0);
    send(8'hA1, 2);
    chk("pe_no_wr", wr_cnt - w0, 0);
    chk("pe_err", err, 1);
    send(8'hA2, 0);
    wait_idle("pe_idle");
    chk("pe_wr_count", wr_cnt - w0, 1);
    chk("pe_byte", wr_log[w0], 8'hA2);
    chk("pe_done_count", done_cnt - d0, 1);
`endif

    chk("done_busy_overlap", db_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
